price_packet_tx: RTL and testbench
==================================

// Module: price_packet_tx
// PURPOSE
//   Serialises one exchange price pair (price_A, price_B) into the 6-byte UART frame
//   consumed by the packet parser: 0xAA, A[15:8], A[7:0], B[15:8], B[7:0], 0x55.
//   Contains its own 8N1 bit serialiser and baud counter, so it drives the TX pin directly.
//   Used to echo or loop back prices, and as the frame source in parser testbenches.
// PARAMETERS
//   CLK_HZ   50000000  system clock frequency in Hz
//   BAUD     115200    line rate; CYCLES_PER_BIT = CLK_HZ/BAUD, truncated (434 at defaults)
//   HEADER   8'hAA     first byte of every frame
//   FOOTER   8'h55     last byte of every frame
// PORTS
//   clk         in   1   system clock (one clock domain)
//   rst         in   1   asynchronous, active-low reset
//   send        in   1   one-cycle request to transmit the current price_A/price_B
//   price_A     in   16  exchange A price; sampled only when a send is accepted
//   price_B     in   16  exchange B price; sampled only when a send is accepted
//   busy        out  1   high from the cycle after acceptance until the frame ends
//   frame_done  out  1   one-cycle pulse when the footer stop bit completes
//   uart_tx     out  1   serial line; idles high
// BEHAVIOUR
//   - Reset (rst=0, async): uart_tx=1, busy=0, frame_done=0, FSM=IDLE, counters=0.
//     Reset mid-frame aborts the frame at once: the line returns high and no frame_done
//     is produced.
//   - Acceptance: a send seen on a clk edge while busy=0 latches {HEADER, A_hi, A_lo,
//     B_hi, B_lo, FOOTER} into a byte buffer, sets byte_idx=0 and enters START.
//     A send while busy=1 is dropped: it is not queued and the latched prices are not
//     changed.
//   - Price inputs may change freely once the send is accepted; the frame uses the
//     latched values.
//   - FSM states and transitions:
//       IDLE
//       START  uart_tx=0 for CYCLES_PER_BIT cycles
//       DATA   8 bits, LSB first, each held CYCLES_PER_BIT cycles
//       STOP   uart_tx=1 for CYCLES_PER_BIT cycles
//     From STOP: if byte_idx<5, increment byte_idx and go to START. If byte_idx==5, go to
//     IDLE and pulse frame_done.
//   - No idle gap between bytes. A frame is exactly 60*CYCLES_PER_BIT cycles, measured
//     from the first start-bit cycle to the last stop-bit cycle.
//   - Latency: the start bit of the header appears on uart_tx on the cycle after the
//     accepting edge. busy rises on that same cycle.
//   - End of frame: frame_done=1 and busy=0 on the same cycle, in the cycle after the
//     last stop-bit cycle. A send on that cycle is accepted, which gives back-to-back
//     frames with no extra idle bit.
//   - Baud counter runs 0..CYCLES_PER_BIT-1 and wraps. Bit and byte indices are
//     3-bit/3-bit and never exceed 7/5.
//   - uart_tx is driven from a register, so it is glitch-free.
//   - Prices are sent as unsigned 16-bit values, high byte first. Any value, including
//     0x0000, 0xAAAA and 0x5555, is sent unmodified; there is no escaping.
// TESTING  (CLK_HZ=1000, BAUD=100, so CYCLES_PER_BIT=10)
//   1. Basic frame: A=0x1234, B=0xABCD, send pulse.
//      -> bytes AA 12 34 AB CD 55, each 8N1 LSB first, 10 cycles per bit.
//      -> busy high for 600 cycles, then one frame_done pulse.
//   2. Send while busy: second send at cycle 200 with A=0xFFFF.
//      -> ignored; the frame stays as in test 1; exactly one frame_done.
//   3. Back-to-back: send asserted on the frame_done cycle with A=0x0001, B=0x0002.
//      -> a second frame AA 00 01 00 02 55 starts next cycle; no gap; two frame_done
//      pulses.
//   4. Reset mid-frame: rst=0 at cycle 250 (inside byte 2).
//      -> uart_tx=1 and busy=0 immediately; no frame_done.
//      -> after release, send with A=0x0BAD, B=0xF00D gives a clean full frame.
//   5. Input change after accept: A changes 0x1111->0x2222 one cycle after send.
//      -> the frame carries 0x11 0x11.
//   6. Loopback: uart_tx into packet_parser with CLK_HZ/BAUD matched, A=0xAAAA,
//      B=0x5555.
//      -> parser pulses packet_valid once with price_A=0xAAAA and price_B=0x5555.

Source files
------------

// File: rtl/price_packet_tx.sv
// Serialises a price pair into a 6-byte 8N1 UART frame:
// HEADER, A_hi, A_lo, B_hi, B_lo, FOOTER, back-to-back with no gap.
module price_packet_tx #(
  parameter int          CLK_HZ = 50000000,
  parameter int          BAUD   = 115200,
  parameter logic [7:0]  HEADER = 8'hAA,
  parameter logic [7:0]  FOOTER = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [15:0] price_A,
  input  logic [15:0] price_B,
  output logic        busy,
  output logic        frame_done,
  output logic        uart_tx
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [2:0]    byte_idx, byte_idx_n;
  logic [47:0]   frame, frame_n;
  logic          tx, tx_n;
  logic          done, done_n;
  logic [7:0]    cur;
  logic [2:0]    nxt_bit;
  logic          bit_end;

  assign busy       = (state != IDLE);
  assign frame_done = done;
  assign uart_tx    = tx;
  assign bit_end    = (cnt == CNT_MAX);
  assign nxt_bit    = bit_idx + 3'd1;

  // Pick the byte currently being shifted out of the latched frame.
  always_comb begin
    cur = 8'hFF;
    case (byte_idx)
      3'd0:    cur = frame[47:40];
      3'd1:    cur = frame[39:32];
      3'd2:    cur = frame[31:24];
      3'd3:    cur = frame[23:16];
      3'd4:    cur = frame[15:8];
      3'd5:    cur = frame[7:0];
      default: cur = 8'hFF;
    endcase
  end

  // State, counters, frame buffer and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      frame    <= frame_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end

  // Next-state logic; tx_n is the line level for the coming cycle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    frame_n    = frame;
    tx_n       = tx;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (send) begin
          frame_n    = {HEADER, price_A, price_B, FOOTER};
          byte_idx_n = '0;
          bit_idx_n  = '0;
          cnt_n      = '0;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          tx_n      = cur[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = nxt_bit;
            tx_n      = cur[nxt_bit];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx == 3'd5) begin
            state_n = IDLE;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = START;
            tx_n       = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_price_packet_tx.sv
// Bench for price_packet_tx: bit-queue line model, UART receiver,
// directed scenarios and randomised frames with send spam.
module tb_price_packet_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [15:0] price_A = '0;
  logic [15:0] price_B = '0;
  logic        busy;
  logic        frame_done;
  logic        uart_tx;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  bit        mq[$];
  bit        done_exp = 1'b0;
  logic [7:0] rxq[$];

  price_packet_tx #(
    .CLK_HZ(1000),
    .BAUD  (100),
    .HEADER(8'hAA),
    .FOOTER(8'h55)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .price_A   (price_A),
    .price_B   (price_B),
    .busy      (busy),
    .frame_done(frame_done),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: an accepted send queues the 600 expected line levels.
  always @(posedge clk or negedge rst) begin
    logic [47:0] f;
    logic [7:0]  by;
    if (!rst) begin
      mq.delete();
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        if (mq.size() == 0) done_exp = 1'b1;
      end else if (send) begin
        f = {8'hAA, price_A, price_B, 8'h55};
        for (int k = 0; k < 6; k++) begin
          by = f[47-8*k -: 8];
          repeat (10) mq.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            repeat (10) mq.push_back(by[b]);
          repeat (10) mq.push_back(1'b1);
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    chk("uart_tx", {31'd0, uart_tx},
        {31'd0, (mq.size() != 0) ? mq[0] : 1'b1});
    chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
    chk("frame_done", {31'd0, frame_done}, {31'd0, done_exp});
  end

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  // Independent UART receiver sampling mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && uart_tx === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    price_A = a;
    price_B = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: frame_done not seen in 700 cycles", name);
    end
  endtask

  task automatic chk_bytes(input string name, input logic [47:0] f0,
                           input logic [47:0] f1, input int nf);
    logic [95:0] all;
    all = {f0, f1};
    chk({name, "_count"}, rxq.size(), 6 * nf);
    for (int i = 0; i < 6 * nf && i < rxq.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {24'd0, rxq[i]},
          {24'd0, all[95-8*i -: 8]});
    rxq.delete();
  endtask

  initial begin
    int n;
    int d0;
    logic [15:0] a;
    logic [15:0] b;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: basic frame, busy duration
    d0 = done_cnt;
    send_frame(16'h1234, 16'hABCD);
    n = 0;
    while (busy === 1'b1 && n < 700) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, 600);
    chk("t1_done_with_idle", {31'd0, frame_done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk_bytes("t1", 48'hAA1234ABCD55, '0, 1);

    // 2: send while busy is dropped
    d0 = done_cnt;
    send_frame(16'h1234, 16'hABCD);
    repeat (198) @(negedge clk);
    price_A = 16'hFFFF;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done("t2");
    repeat (3) @(negedge clk);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk_bytes("t2", 48'hAA1234ABCD55, '0, 1);

    // 3: back-to-back on the frame_done cycle
    d0 = done_cnt;
    send_frame(16'h1234, 16'hABCD);
    wait_done("t3a");
    price_A = 16'h0001;
    price_B = 16'h0002;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("t3_busy_again", {31'd0, busy}, 32'd1);
    chk("t3_start_bit", {31'd0, uart_tx}, 32'd0);
    wait_done("t3b");
    repeat (3) @(negedge clk);
    chk("t3_done_pulses", done_cnt - d0, 2);
    chk_bytes("t3", 48'hAA1234ABCD55, 48'hAA00010002_55, 2);

    // 4: reset mid-frame
    d0 = done_cnt;
    send_frame(16'h1234, 16'hABCD);
    repeat (248) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t4_tx_async", {31'd0, uart_tx}, 32'd1);
    chk("t4_busy_async", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    repeat (120) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    rxq.delete();
    send_frame(16'h0BAD, 16'hF00D);
    wait_done("t4");
    repeat (3) @(negedge clk);
    chk_bytes("t4", 48'hAA0BADF00D55, '0, 1);

    // 5: input change after accept
    @(negedge clk);
    price_A = 16'h1111;
    price_B = 16'h2468;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    price_A = 16'h2222;
    wait_done("t5");
    repeat (3) @(negedge clk);
    chk_bytes("t5", 48'hAA11112468_55, '0, 1);

    // 6: header/footer-like price values go through unmodified
    send_frame(16'hAAAA, 16'h5555);
    wait_done("t6");
    repeat (3) @(negedge clk);
    chk_bytes("t6", 48'hAAAAAA555555, '0, 1);

    // 7: randomised frames with spurious sends during busy
    for (int r = 0; r < 6; r++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (r == 0) begin a = 16'h0000; b = 16'h0000; end
      d0 = done_cnt;
      send_frame(a, b);
      repeat ($urandom_range(1, 3)) begin
        repeat ($urandom_range(20, 150)) @(negedge clk);
        price_A = 16'($urandom);
        price_B = 16'($urandom);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
      wait_done("t7");
      repeat (3) @(negedge clk);
      chk("t7_done_pulses", done_cnt - d0, 1);
      chk_bytes("t7", {8'hAA, a, b, 8'h55}, '0, 1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
